// File: rtl/eth_fcs_append_ctrl.sv
// eth_fcs_append_ctrl: TX frame controller. It forwards an 8-bit AXI-stream
// payload, zero-pads short frames (only when ETH_FCS_PAD_EN is defined),
// then appends the CRC32 FCS least-significant byte first.
// Ports: clk, rst (synchronous, active-high),
//   s_axis_{tdata,tvalid,tready,tlast,tuser}  payload in,
//   m_axis_{tdata,tvalid,tready,tlast,tuser}  frame out (one register stage),
//   busy  high from the first accepted byte until the closing tlast transfers.
// Macro ETH_FCS_PAD_EN: compile in the PAD state and the byte counter.
module eth_fcs_append_ctrl #(
   parameter int MIN_FRAME_LENGTH = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PAYLOAD = 2'd1,
`ifdef ETH_FCS_PAD_EN
      S_PAD     = 2'd2,
`endif
      S_FCS     = 2'd3
   } state_t;

   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   // Reflected (LSB-first) Galois step of poly 04C11DB7, one byte.
   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] v;
      v = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         if (v[0]) v = (v >> 1) ^ 32'hEDB8_8320;
         else      v = v >> 1;
      end
      return v;
   endfunction

   state_t      r_state;
   logic [31:0] r_crc;
   logic [1:0]  r_idx;
   logic [7:0]  r_m_tdata;
   logic        r_m_tvalid;
   logic        r_m_tlast;
   logic        r_m_tuser;
   logic        r_busy;

   logic        w_out_rdy;
   logic        w_in_state;
   logic        w_accept;
   logic        w_tlast_xfer;
   logic [31:0] w_fcs;
   logic [7:0]  w_fcs_byte;

`ifdef ETH_FCS_PAD_EN
   localparam logic [11:0] PAD_TGT = 12'(MIN_FRAME_LENGTH - 4);
   logic [11:0] r_count;
   logic [11:0] w_count_inc;
   // Counter saturates so long frames never wrap into a false "short".
   assign w_count_inc = (r_count == PAD_TGT) ? r_count
                                             : r_count + 12'd1;
`else
   logic w_unused_min;
   assign w_unused_min = |MIN_FRAME_LENGTH;
`endif

   assign w_out_rdy    = !r_m_tvalid || m_axis_tready;
   assign w_in_state   = (r_state == S_IDLE) ||
                         (r_state == S_PAYLOAD);
   assign w_accept     = s_axis_tvalid && s_axis_tready;
   assign w_tlast_xfer = r_m_tvalid && m_axis_tready && r_m_tlast;
   assign w_fcs        = ~r_crc;

   always_comb begin
      w_fcs_byte = w_fcs[7:0];
      unique case (r_idx)
         2'd0: w_fcs_byte = w_fcs[7:0];
         2'd1: w_fcs_byte = w_fcs[15:8];
         2'd2: w_fcs_byte = w_fcs[23:16];
         2'd3: w_fcs_byte = w_fcs[31:24];
      endcase
   end

   // Gated by rst so the input is never accepted while reset is held.
   assign s_axis_tready = !rst && w_in_state && w_out_rdy;

   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tlast  = r_m_tlast;
   assign m_axis_tuser  = r_m_tuser;
   assign busy          = r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_crc      <= CRC_INIT;
         r_idx      <= 2'd0;
         r_m_tdata  <= 8'd0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_m_tuser  <= 1'b0;
         r_busy     <= 1'b0;
`ifdef ETH_FCS_PAD_EN
         r_count    <= 12'd0;
`endif
      end else begin
         // A new frame may start in the same cycle the old one ends.
         if (w_accept)          r_busy <= 1'b1;
         else if (w_tlast_xfer) r_busy <= 1'b0;

         unique case (r_state)
            S_IDLE, S_PAYLOAD: begin
               if (w_accept) begin
                  r_m_tdata  <= s_axis_tdata;
                  r_m_tvalid <= 1'b1;
                  r_m_tlast  <= 1'b0;
                  r_m_tuser  <= 1'b0;
                  r_crc      <= crc_byte(r_crc, s_axis_tdata);
                  r_state    <= S_PAYLOAD;
`ifdef ETH_FCS_PAD_EN
                  r_count    <= w_count_inc;
`endif
                  if (s_axis_tlast) begin
                     if (s_axis_tuser) begin
                        // Bad frame: close it here, no FCS.
                        r_m_tlast <= 1'b1;
                        r_m_tuser <= 1'b1;
                        r_state   <= S_IDLE;
                        r_crc     <= CRC_INIT;
`ifdef ETH_FCS_PAD_EN
                        r_count   <= 12'd0;
                     end else if (w_count_inc < PAD_TGT) begin
                        r_state   <= S_PAD;
`endif
                     end else begin
                        r_state   <= S_FCS;
                        r_idx     <= 2'd0;
                     end
                  end
               end else if (w_out_rdy) begin
                  r_m_tvalid <= 1'b0;
               end
            end
`ifdef ETH_FCS_PAD_EN
            S_PAD: begin
               if (w_out_rdy) begin
                  r_m_tdata  <= 8'h00;
                  r_m_tvalid <= 1'b1;
                  r_m_tlast  <= 1'b0;
                  r_m_tuser  <= 1'b0;
                  r_crc      <= crc_byte(r_crc, 8'h00);
                  r_count    <= w_count_inc;
                  if (w_count_inc == PAD_TGT) begin
                     r_state <= S_FCS;
                     r_idx   <= 2'd0;
                  end
               end
            end
`endif
            S_FCS: begin
               if (w_out_rdy) begin
                  r_m_tdata  <= w_fcs_byte;
                  r_m_tvalid <= 1'b1;
                  r_m_tlast  <= (r_idx == 2'd3);
                  r_m_tuser  <= 1'b0;
                  r_idx      <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_state <= S_IDLE;
                     r_crc   <= CRC_INIT;
`ifdef ETH_FCS_PAD_EN
                     r_count <= 12'd0;
`endif
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
